// File: rtl/pool_pkg.sv
// Shared types, parameter-word layout and helpers for the pooling engine.
package pool_pkg;

  localparam int RAM_AW = 32;
  localparam int RAM_DW = 32;
  // Channel count is taken from the low 16 bits of its parameter word.
  localparam int C_FW = 16;

  localparam logic WRITE_ENB = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

  localparam logic [1:0] PADDR_H  = 2'd0;
  localparam logic [1:0] PADDR_W  = 2'd1;
  localparam logic [1:0] PADDR_C  = 2'd2;
  localparam logic [1:0] PADDR_KM = 2'd3;
  localparam int MODE_BIT = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_PARAM = 3'd1,
    CHECK      = 3'd2,
    READ       = 3'd3,
    DRAIN      = 3'd4,
    WRITE      = 3'd5,
    DONE       = 3'd6
  } state_t;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } mode_t;

  function automatic logic k_legal(input logic [3:0] k, input int max_k);
    return ((k == 4'd1) || (k == 4'd2) || (k == 4'd4)) && (int'(k) <= max_k);
  endfunction

  function automatic logic [1:0] k_log2(input logic [3:0] k);
    case (k)
      4'd2:    return 2'd1;
      4'd4:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pool_engine_if.sv
// Single-port SRAM interface shared by the EPU compute engines.
interface sp_ram_intf;
  import pool_pkg::*;

  logic              cs;
  logic              oe;
  logic [RAM_AW-1:0] addr;
  logic              W_req;
  logic [RAM_DW-1:0] W_data;
  logic [RAM_DW-1:0] R_data;

  modport compute (output cs, oe, addr, W_req, W_data, input R_data);
  modport memory  (input cs, oe, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/pool_reduce.sv
// Window reduction datapath: signed max or signed sum with arithmetic-shift average.
module pool_reduce
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAX_K  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  mode_t             mode,
  input  logic [2:0]        shift,
  output logic [DATA_W-1:0] result
);

  localparam int ACC_W = DATA_W + 2 * $clog2(MAX_K);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] data_ext;
  logic signed [ACC_W-1:0] max_init;
  logic signed [ACC_W-1:0] shifted;

  assign data_ext = ACC_W'($signed(data));
  assign max_init = ACC_W'($signed({1'b1, {(DATA_W-1){1'b0}}}));

  always_comb begin
    acc_next = acc;
    if (mode == POOL_AVG) begin
      acc_next = acc + data_ext;
    end else if (data_ext > acc) begin
      acc_next = data_ext;
    end else begin
      acc_next = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= (mode == POOL_MAX) ? max_init : '0;
    end else if (valid) begin
      acc <= acc_next;
    end else begin
      acc <= acc;
    end
  end

  // In max mode the accumulator never leaves the DATA_W signed range.
  always_comb begin
    shifted = acc >>> shift;
    if (mode == POOL_AVG) begin
      result = shifted[DATA_W-1:0];
    end else begin
      result = acc[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/pool_engine.sv
// 2-D K x K stride-K pooling engine: parameter load, legality check, channel-major window walk.
module pool_engine
  import pool_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 64,
  parameter int MAX_K   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic finish,
  output logic error,
  sp_ram_intf.compute param_intf,
  sp_ram_intf.compute input_intf,
  sp_ram_intf.compute output_intf
);

  localparam int DIM_W = $clog2(MAX_DIM + 1);

  state_t state;
  state_t state_nx;

  logic [1:0]        pidx;
  logic [RAM_DW-1:0] h_word, w_word, c_word;
  logic [3:0]        k;
  logic [3:0]        k_in;
  logic [1:0]        klog;
  mode_t             mode;
  logic [3:0]        kx, ky;
  logic [DIM_W-1:0]  ox, oy, ho, wo;
  logic [C_FW-1:0]   c_cnt, c_num;
  logic [RAM_AW-1:0] hw, kw, k_ext;
  logic [RAM_AW-1:0] ch_base, row_base, win_base, line_addr, out_addr;
  logic              rd_valid;
  logic              legal;
  logic              win_end, last_col, last_row, last_chan;
  logic [DATA_W-1:0] result;

  assign k_in  = param_intf.R_data[3:0];
  assign klog  = k_log2(k);
  assign ho    = h_word[DIM_W-1:0] >> klog;
  assign wo    = w_word[DIM_W-1:0] >> klog;
  assign c_num = c_word[C_FW-1:0];
  assign k_ext = RAM_AW'(k);
  assign kw    = RAM_AW'(w_word[DIM_W-1:0]) << klog;

  assign win_end   = (kx == (k - 4'd1)) && (ky == (k - 4'd1));
  assign last_col  = (ox == (wo - DIM_W'(1)));
  assign last_row  = (oy == (ho - DIM_W'(1)));
  assign last_chan = (c_cnt == (c_num - C_FW'(1)));

  // K arrives on the read bus during CHECK, the other words are already captured.
  assign legal = (h_word != '0) && (w_word != '0) && (c_num != '0) &&
                 (h_word <= RAM_DW'(MAX_DIM)) && (w_word <= RAM_DW'(MAX_DIM)) &&
                 k_legal(k_in, MAX_K) &&
                 (RAM_DW'(k_in) <= h_word) && (RAM_DW'(k_in) <= w_word);

  pool_reduce #(.DATA_W(DATA_W), .MAX_K(MAX_K)) u_reduce (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == READ) && (kx == 4'd0) && (ky == 4'd0)),
    .valid  (rd_valid),
    .data   (input_intf.R_data[DATA_W-1:0]),
    .mode   (mode),
    .shift  ({klog, 1'b0}),
    .result (result)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (start) state_nx = LOAD_PARAM; else state_nx = IDLE;
      LOAD_PARAM: if (pidx == 2'd3) state_nx = CHECK; else state_nx = LOAD_PARAM;
      CHECK:      if (legal) state_nx = READ; else state_nx = DONE;
      READ:       if (win_end) state_nx = DRAIN; else state_nx = READ;
      DRAIN:      state_nx = WRITE;
      WRITE:      if (last_col && last_row && last_chan) state_nx = DONE; else state_nx = READ;
      DONE:       if (!start) state_nx = IDLE; else state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // FSM outputs: SRAM strobes and addresses decoded from registered state.
  always_comb begin
    param_intf.oe      = 1'b1;
    param_intf.cs      = (state == LOAD_PARAM);
    param_intf.addr    = RAM_AW'(pidx);
    param_intf.W_req   = WRITE_DIS;
    param_intf.W_data  = '0;
    input_intf.oe      = 1'b1;
    input_intf.cs      = (state == READ);
    input_intf.addr    = line_addr + RAM_AW'(kx);
    input_intf.W_req   = WRITE_DIS;
    input_intf.W_data  = '0;
    output_intf.oe     = 1'b1;
    output_intf.cs     = (state == WRITE);
    output_intf.W_req  = (state == WRITE) ? WRITE_ENB : WRITE_DIS;
    output_intf.addr   = out_addr;
    output_intf.W_data = RAM_DW'(result);
  end

  // Parameter capture, window counters and address pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pidx <= 2'd0; h_word <= '0; w_word <= '0; c_word <= '0;
      k <= 4'd0; mode <= POOL_MAX; hw <= '0;
      kx <= 4'd0; ky <= 4'd0; ox <= '0; oy <= '0; c_cnt <= '0;
      ch_base <= '0; row_base <= '0; win_base <= '0; line_addr <= '0; out_addr <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == READ);
      case (state)
        IDLE: pidx <= 2'd0;
        LOAD_PARAM: begin
          pidx <= pidx + 2'd1;
          case (pidx)
            2'd1:    h_word <= param_intf.R_data;
            2'd2:    w_word <= param_intf.R_data;
            2'd3:    c_word <= param_intf.R_data;
            default: h_word <= h_word;
          endcase
        end
        CHECK: begin
          k <= k_in;
          mode <= mode_t'(param_intf.R_data[MODE_BIT]);
          hw <= RAM_AW'(h_word[DIM_W-1:0]) * RAM_AW'(w_word[DIM_W-1:0]);
          kx <= 4'd0; ky <= 4'd0; ox <= '0; oy <= '0; c_cnt <= '0;
          ch_base <= '0; row_base <= '0; win_base <= '0; line_addr <= '0; out_addr <= '0;
        end
        READ: begin
          if (kx == (k - 4'd1)) begin
            kx <= 4'd0;
            line_addr <= line_addr + RAM_AW'(w_word[DIM_W-1:0]);
            if (ky == (k - 4'd1)) ky <= 4'd0; else ky <= ky + 4'd1;
          end else begin
            kx <= kx + 4'd1;
          end
        end
        // Each write advances to the next window start: column, then row band, then channel.
        WRITE: begin
          out_addr <= out_addr + RAM_AW'(1);
          if (!last_col) begin
            ox <= ox + DIM_W'(1);
            win_base <= win_base + k_ext;
            line_addr <= win_base + k_ext;
          end else if (!last_row) begin
            ox <= '0;
            oy <= oy + DIM_W'(1);
            row_base <= row_base + kw;
            win_base <= row_base + kw;
            line_addr <= row_base + kw;
          end else begin
            ox <= '0;
            oy <= '0;
            c_cnt <= c_cnt + C_FW'(1);
            ch_base <= ch_base + hw;
            row_base <= ch_base + hw;
            win_base <= ch_base + hw;
            line_addr <= ch_base + hw;
          end
        end
        default: pidx <= pidx;
      endcase
    end
  end

  // Registered completion flags, held for the whole of DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      finish <= 1'b0;
      error  <= 1'b0;
    end else begin
      finish <= (state_nx == DONE);
      if (state == CHECK) begin
        error <= !legal;
      end else if (state_nx != DONE) begin
        error <= 1'b0;
      end else begin
        error <= error;
      end
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine: table vectors, hand sequences and random layers against a window model.
module tb_pool_engine;
  import pool_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start8, start16;
  logic finish8, error8, finish16, error16;

  sp_ram_intf p8(), i8(), o8(), p16(), i16(), o16();

  pool_engine #(.DATA_W(8), .MAX_DIM(64), .MAX_K(4)) u8 (
    .clk(clk), .rst(rst), .start(start8), .finish(finish8), .error(error8),
    .param_intf(p8), .input_intf(i8), .output_intf(o8));

  pool_engine #(.DATA_W(16), .MAX_DIM(64), .MAX_K(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .finish(finish16), .error(error16),
    .param_intf(p16), .input_intf(i16), .output_intf(o16));

  logic [31:0] pmem [4];
  logic [31:0] imem [1024];
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int nrd, badrd, overlap;
  int total, bad;
  int cur_h, cur_w, cur_c, cur_k;

  typedef struct {
    int h, w, c, k, mode, pat, exp_err, exp_wr, exp_cyc;
    longint exp_first, exp_last;
  } vec_t;
  vec_t tbl [8];
  longint gold [4];

  // One-cycle-latency SRAMs shared by both engines.
  always @(posedge clk) begin
    if (p8.cs && p8.oe)   p8.R_data  <= pmem[p8.addr[1:0]];
    if (i8.cs && i8.oe)   i8.R_data  <= imem[i8.addr[9:0]];
    if (p16.cs && p16.oe) p16.R_data <= pmem[p16.addr[1:0]];
    if (i16.cs && i16.oe) i16.R_data <= imem[i16.addr[9:0]];
  end

  function automatic bit in_window(input int a);
    int hw, cc, r, y, x;
    hw = cur_h * cur_w;
    if (hw == 0 || !(cur_k == 1 || cur_k == 2 || cur_k == 4)) return 1'b0;
    cc = a / hw; r = a % hw; y = r / cur_w; x = r % cur_w;
    return (cc < cur_c) && (y < (cur_h / cur_k) * cur_k) && (x < (cur_w / cur_k) * cur_k);
  endfunction

  // Mid-cycle observation of writes, reads and strobe exclusivity.
  always @(negedge clk) begin
    if (o8.cs && o8.W_req == WRITE_ENB)   begin wa.push_back(o8.addr);  wd.push_back(o8.W_data);  end
    if (o16.cs && o16.W_req == WRITE_ENB) begin wa.push_back(o16.addr); wd.push_back(o16.W_data); end
    if (i8.cs)  begin nrd++; if (!in_window(int'(i8.addr)))  badrd++; end
    if (i16.cs) begin nrd++; if (!in_window(int'(i16.addr))) badrd++; end
    if (int'(p8.cs) + int'(i8.cs) + int'(o8.cs) > 1) overlap++;
    if (int'(p16.cs) + int'(i16.cs) + int'(o16.cs) > 1) overlap++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit model_legal(input int h, w, c, k);
    return h > 0 && w > 0 && c > 0 && h <= 64 && w <= 64 &&
           (k == 1 || k == 2 || k == 4) && k <= 4 && k <= h && k <= w;
  endfunction

  // Window result from the pooling rules: signed max, or floor of the mean.
  function automatic longint model_val(input int dw, h, w, k, mode, idx);
    int ho, wo, cc, r, oy, ox, a;
    longint best, sum, v, q, mask, n;
    ho = h / k; wo = w / k;
    cc = idx / (ho * wo); r = idx % (ho * wo); oy = r / wo; ox = r % wo;
    mask = (longint'(1) << dw) - 1;
    best = -(longint'(1) << (dw - 1));
    sum = 0;
    for (int ky = 0; ky < k; ky++) begin
      for (int kx = 0; kx < k; kx++) begin
        a = cc * h * w + (oy * k + ky) * w + ox * k + kx;
        v = longint'(imem[a]) & mask;
        if (v >= (longint'(1) << (dw - 1))) v = v - (longint'(1) << dw);
        if (v > best) best = v;
        sum += v;
      end
    end
    n = k * k;
    if (mode == 0) begin
      q = best;
    end else begin
      q = sum / n;
      if ((sum % n) != 0 && sum < 0) q = q - 1;
    end
    return q & mask;
  endfunction

  task automatic fill(input int pat);
    for (int i = 0; i < 1024; i++) begin
      case (pat)
        0: imem[i] = i;
        1: imem[i] = 32'hFFFF_FFFD;
        2: imem[i] = $urandom();
        3: imem[i] = (i == 0) ? 32'hFFFF_FFFF : 32'h0;
        default: imem[i] = i * 3 - 40;
      endcase
    end
  endtask

  task automatic run_layer(input int sel, h, w, c, k, mode, output int cyc, output logic err_o);
    pmem[0] = h; pmem[1] = w; pmem[2] = c; pmem[3] = (mode << 8) | k;
    cur_h = h; cur_w = w; cur_c = c; cur_k = k;
    wa.delete(); wd.delete(); nrd = 0; badrd = 0; overlap = 0;
    if (sel == 0) start8 = 1'b1; else start16 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    cyc = 1;
    while (!((sel == 0) ? finish8 : finish16) && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    err_o = (sel == 0) ? error8 : error16;
    @(posedge clk); #1;
    chk("finish_fall", (sel == 0) ? finish8 : finish16, 0);
    chk("error_fall", (sel == 0) ? error8 : error16, 0);
  endtask

  task automatic verify(input int dw, h, w, c, k, mode, cyc, input logic err);
    bit lg;
    int n;
    lg = model_legal(h, w, c, k);
    n = lg ? c * (h / k) * (w / k) : 0;
    chk("error", err, !lg);
    chk("cycles", cyc, 4 + 1 + n * (k * k + 2) + 1);
    chk("writes", wa.size(), n);
    chk("reads", nrd, lg ? n * k * k : 0);
    chk("stray_reads", badrd, 0);
    chk("cs_overlap", overlap, 0);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk("wr_addr", wa[i], i);
      chk("wr_data", wd[i], model_val(dw, h, w, k, mode, i));
    end
  endtask

  initial begin
    int cyc, t;
    logic err;
    int klist [6];
    int h, w, c, k, m;
    total = 0; bad = 0;
    klist[0] = 1; klist[1] = 2; klist[2] = 3; klist[3] = 4; klist[4] = 5; klist[5] = 8;
    gold[0] = 5; gold[1] = 7; gold[2] = 13; gold[3] = 15;
    //            h  w  c  k  md pat err wr cyc  first last
    tbl[0] = '{4, 4, 1, 2, 0, 0, 0, 4, 30, 5, 15};
    tbl[1] = '{4, 4, 2, 2, 1, 1, 0, 8, 54, 253, 253};
    tbl[2] = '{5, 6, 1, 2, 0, 4, 0, 6, 42, 237, 29};
    tbl[3] = '{4, 4, 1, 3, 0, 0, 1, 0, 6, -1, -1};
    tbl[4] = '{0, 4, 1, 2, 0, 0, 1, 0, 6, -1, -1};
    tbl[5] = '{4, 4, 1, 2, 1, 3, 0, 4, 30, 255, 0};
    tbl[6] = '{4, 4, 1, 4, 1, 2, 0, 1, 24, -1, -1};
    tbl[7] = '{2, 8, 1, 4, 0, 0, 1, 0, 6, -1, -1};

    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_finish", finish8, 0);
    chk("reset_error", error8, 0);
    chk("reset_cs", int'(p8.cs) + int'(i8.cs) + int'(o8.cs), 0);
    chk("reset_wreq", o8.W_req, WRITE_DIS);
    chk("reset_oaddr", o8.addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      fill(tbl[i].pat);
      run_layer(0, tbl[i].h, tbl[i].w, tbl[i].c, tbl[i].k, tbl[i].mode, cyc, err);
      chk("tbl_cycles", cyc, tbl[i].exp_cyc);
      chk("tbl_error", err, tbl[i].exp_err);
      chk("tbl_writes", wa.size(), tbl[i].exp_wr);
      if (tbl[i].exp_first >= 0 && wa.size() > 0) begin
        chk("tbl_first", wd[0], tbl[i].exp_first);
        chk("tbl_last", wd[wa.size() - 1], tbl[i].exp_last);
      end
      verify(8, tbl[i].h, tbl[i].w, tbl[i].c, tbl[i].k, tbl[i].mode, cyc, err);
    end

    // Reset during the second window's reads, then a clean restart.
    fill(0);
    pmem[0] = 4; pmem[1] = 4; pmem[2] = 1; pmem[3] = 2;
    cur_h = 4; cur_w = 4; cur_c = 1; cur_k = 2;
    wa.delete(); wd.delete();
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    t = 0;
    while (wa.size() < 1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("rst_first_write", wa.size(), 1);
    @(posedge clk); #1;
    chk("rst_in_read", i8.cs, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_state", longint'(u8.state), longint'(IDLE));
    chk("rst_cs", int'(p8.cs) + int'(i8.cs) + int'(o8.cs), 0);
    chk("rst_wreq", o8.W_req, WRITE_DIS);
    chk("rst_iaddr", i8.addr, 0);
    chk("rst_oaddr", o8.addr, 0);
    chk("rst_finish", finish8, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_write", wa.size(), 1);
    run_layer(0, 4, 4, 1, 2, 0, cyc, err);
    verify(8, 4, 4, 1, 2, 0, cyc, err);
    for (int j = 0; j < 4 && j < wa.size(); j++) chk("restart_golden", wd[j], gold[j]);

    // 16-bit engine with full-range values.
    fill(2);
    imem[5] = 32'h0000_7FFF;
    imem[40] = 32'hFFFF_8000;
    run_layer(1, 8, 8, 1, 4, 0, cyc, err);
    verify(16, 8, 8, 1, 4, 0, cyc, err);
    run_layer(1, 8, 8, 2, 2, 1, cyc, err);
    verify(16, 8, 8, 2, 2, 1, cyc, err);

    // Random layers, including illegal shapes.
    for (int r = 0; r < 10; r++) begin
      h = $urandom_range(0, 12);
      w = $urandom_range(0, 12);
      c = $urandom_range(0, 3);
      k = klist[$urandom_range(0, 5)];
      m = $urandom_range(0, 1);
      fill(2);
      run_layer(0, h, w, c, k, m, cyc, err);
      verify(8, h, w, c, k, m, cyc, err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_engine.md
# pool_engine

Parametrised 2-D pooling engine for the EPU, the successor to the fixed max-pool unit. Per layer it reads a 4-word parameter block, then walks every channel of a channel-major feature map in SRAM and writes one result per non-overlapping K×K window (stride K). It supports signed max- and average-pooling, non-square maps, and a configurable data width. It shares the EPU SRAM interfaces with the other compute engines and is launched by the EPU controller via `start`/`finish`.

## Interface
Parameters:
- DATA_W, 8, element width in bits; signed two's complement.
- MAX_DIM, 64, largest legal H or W.
- MAX_K, 4, largest legal kernel size; must be a power of two.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request, sampled in IDLE only.
- finish  out  1  high in DONE.
- error  out  1  high in DONE if the parameters were illegal.
- param_intf  sp_ram_intf.compute  -  parameter SRAM port; read only.
- input_intf  sp_ram_intf.compute  -  feature-map SRAM port; read only.
- output_intf  sp_ram_intf.compute  -  result SRAM port; write only; W_data is {zero pad, result[DATA_W-1:0]}.

## Operation
- Parameter words:
  - addr0: H.
  - addr1: W.
  - addr2: C (channels).
  - addr3: bits [3:0] K, bit [8] mode (0 = max, 1 = avg).
- Parameter check. Illegal if any of:
  - H, W or C is 0;
  - H or W exceeds MAX_DIM;
  - K is not in {1, 2, 4}, or K exceeds MAX_K;
  - K > H or K > W.
  - Illegal parameters → DONE with error=1 and no output writes.
- Output size: Ho=floor(H/K), Wo=floor(W/K). Trailing rows and columns that do not fill a window are dropped.
- Addressing:
  - Input element: c·H·W + y·W + x.
  - Output element: c·Ho·Wo + oy·Wo + ox.
  - Traversal order: c outer, then oy, then ox, then window rows, then window columns.
- Max mode:
  - Accumulator initialises to the most-negative DATA_W value.
  - Each element is combined with a signed compare.
- Avg mode:
  - Signed sum held in an accumulator of DATA_W+2·log2(MAX_K) bits.
  - Result = sum >>> log2(K·K), an arithmetic shift (rounds toward −∞), then truncated to DATA_W bits.
- States:
  - IDLE → LOAD_PARAM on start.
  - LOAD_PARAM → CHECK after 4 reads.
  - CHECK → READ if parameters are legal; CHECK → DONE (error=1) if not.
  - READ → DRAIN after K·K addresses have been issued.
  - DRAIN → WRITE.
  - WRITE → READ if windows remain; WRITE → DONE after the last window.
  - DONE → IDLE when start=0.
- start asserted outside IDLE is ignored.

## Timing
- SRAM read latency is 1 cycle: the address and cs issued in cycle t give R_data in cycle t+1.
- The accumulator folds in read data one cycle after each address, so DRAIN absorbs the last element.
- Per window: K·K READ cycles + 1 DRAIN + 1 WRITE.
- Layer total: 4 + 1 + C·Ho·Wo·(K·K+2) cycles, plus 1 for DONE.
- WRITE: output cs=1 and W_req=WRITE_ENB for exactly one cycle, with addr and W_data stable. Output addr increments after the write.
- cs is asserted only on the port being accessed in the current state. oe is tied to 1 on all ports.
- finish and error are registered. Both stay high throughout DONE and fall in the cycle after start is sampled low.
- Reset is synchronous and valid mid-layer. Next cycle:
  - state = IDLE;
  - every cs=0, W_req=WRITE_DIS;
  - addresses = 0, accumulator = 0;
  - finish=0, error=0;
  - no partial write completes.
- Address counters have enough width for C·H·W with no wrap. The output address equals C·Ho·Wo−1 on the last write.

## Structure
- Shared package pool_pkg holds:
  - the state enum (IDLE, LOAD_PARAM, CHECK, READ, DRAIN, WRITE, DONE);
  - the mode enum (POOL_MAX, POOL_AVG);
  - parameter-word address constants;
  - the K legality function.
- Sub-module pool_reduce holds the accumulator, compare/add datapath and avg shift. Its inputs are clear, valid, data, mode and shift; its output is result.
- The top level holds the FSM, counters (kx, ky, ox, oy, c) and address generation.

## Test plan
- H=W=4, C=1, K=2, max; input 0..15 → 4 writes of 5, 7, 13, 15 to addr 0..3; finish after 4+1+4·6+1 cycles.
- H=W=4, C=2, K=2, avg; all inputs −3 → 8 writes of −3 (0xFD); a window {−1, 0, 0, 0} gives −1 (floor).
- H=5, W=6, C=1, K=2, max; distinct values → 2×3=6 writes; the last row and last column are never read.
- K=3 or H=0 → DONE with error=1; zero output W_req pulses.
- rst asserted mid-READ of window 2 → next cycle IDLE with all cs=0; a restart reproduces golden output.
- DATA_W=16, K=4, max, H=W=8, C=1, values spanning −32768..32767 → the signed max per window matches the model.
